// File: rtl/freq_meas_ctrl_if.sv
// rtl/freq_meas_ctrl_if.sv - control/result bundle between frequency-measurement sequencer and its reader
interface freq_meas_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             cont;
  logic             rd_ack;
  logic             busy;
  logic             done;
  logic             result_valid;
  logic             timeout;
  logic [CNT_W-1:0] sig_cnt;
  logic [CNT_W-1:0] ref_cnt;
  logic [CNT_W-1:0] high_cnt;

  modport master (
    output start, cont, rd_ack,
    input  busy, done, result_valid, timeout, sig_cnt, ref_cnt, high_cnt
  );

  modport slave (
    input  start, cont, rd_ack,
    output busy, done, result_valid, timeout, sig_cnt, ref_cnt, high_cnt
  );
endinterface

// File: rtl/freq_meas_ctrl.sv
// rtl/freq_meas_ctrl.sv - reciprocal-counting frequency/duty measurement sequencer
// Gate opens on a signal rise, runs GATE_CLKS cycles minimum, closes on the next rise.
module freq_meas_ctrl #(
  parameter int unsigned GATE_CLKS    = 48000000,
  parameter int unsigned TIMEOUT_CLKS = 96000000,
  parameter int          CNT_W        = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              sig_in,
  freq_meas_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ARM, GATE, CLOSE} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CLKS - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CLKS - 1);

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] ref_acc_q, ref_acc_d;
  logic [CNT_W-1:0] sig_acc_q, sig_acc_d;
  logic [CNT_W-1:0] high_acc_q, high_acc_d;
  logic [CNT_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0] sig_cnt_q, sig_cnt_d;
  logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  logic             level, rise, tmo_hit, fin_close, fin_abort;
  logic [CNT_W-1:0] ref_inc, sig_inc, high_inc;

  assign level   = s2_q;
  assign rise    = s2_q & ~s3_q;
  // A rise always resets the watchdog, so it can never fire in the same cycle as an edge.
  assign tmo_hit = (tmo_cnt_q == TMO_LAST) && !rise;

  assign ref_inc  = (ref_acc_q == CNT_MAX)           ? ref_acc_q  : ref_acc_q + 1'b1;
  assign sig_inc  = (rise  && sig_acc_q  != CNT_MAX) ? sig_acc_q  + 1'b1 : sig_acc_q;
  assign high_inc = (level && high_acc_q != CNT_MAX) ? high_acc_q + 1'b1 : high_acc_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      ref_acc_q  <= '0;
      sig_acc_q  <= '0;
      high_acc_q <= '0;
      gate_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      sig_cnt_q  <= '0;
      ref_cnt_q  <= '0;
      high_cnt_q <= '0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= sig_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      ref_acc_q  <= ref_acc_d;
      sig_acc_q  <= sig_acc_d;
      high_acc_q <= high_acc_d;
      gate_cnt_q <= gate_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      sig_cnt_q  <= sig_cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      high_cnt_q <= high_cnt_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ref_acc_d  = ref_acc_q;
    sig_acc_d  = sig_acc_q;
    high_acc_d = high_acc_q;
    gate_cnt_d = gate_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    sig_cnt_d  = sig_cnt_q;
    ref_cnt_d  = ref_cnt_q;
    high_cnt_d = high_cnt_q;
    timeout_d  = timeout_q;
    fin_close  = 1'b0;
    fin_abort  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = ARM;
          tmo_cnt_d = '0;
        end
      end
      ARM: begin
        // The opening edge starts the window but is not itself counted.
        if (rise) begin
          ref_acc_d  = '0;
          sig_acc_d  = '0;
          high_acc_d = '0;
          gate_cnt_d = '0;
          tmo_cnt_d  = '0;
          state_d    = GATE;
        end else if (tmo_hit) begin
          fin_abort = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      GATE, CLOSE: begin
        ref_acc_d  = ref_inc;
        sig_acc_d  = sig_inc;
        high_acc_d = high_inc;
        tmo_cnt_d  = rise ? '0 : tmo_cnt_q + 1'b1;
        if (state_q == GATE) begin
          gate_cnt_d = gate_cnt_q + 1'b1;
          if (gate_cnt_q == GATE_LAST) begin
            if (rise) fin_close = 1'b1;
            else      state_d   = CLOSE;
          end
        end else if (rise) begin
          fin_close = 1'b1;
        end
        if (tmo_hit) fin_abort = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (fin_close) begin
      sig_cnt_d  = sig_inc;
      ref_cnt_d  = ref_inc;
      high_cnt_d = high_inc;
      timeout_d  = 1'b0;
    end
    if (fin_abort) begin
      sig_cnt_d  = '0;
      ref_cnt_d  = '0;
      high_cnt_d = '0;
      timeout_d  = 1'b1;
    end

    done_d = fin_close | fin_abort;
    if (done_d) begin
      state_d   = bus.cont ? ARM : IDLE;
      tmo_cnt_d = '0;
    end

    // An ack arriving alongside a result (being produced or just presented) must not hide it.
    if (done_d)                     valid_d = 1'b1;
    else if (bus.rd_ack && !done_q) valid_d = 1'b0;
    else                            valid_d = valid_q;
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;
  assign bus.result_valid = valid_q;
  assign bus.timeout      = timeout_q;
  assign bus.sig_cnt      = sig_cnt_q;
  assign bus.ref_cnt      = ref_cnt_q;
  assign bus.high_cnt     = high_cnt_q;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// tb/tb_freq_meas_ctrl.sv - directed bench for freq_meas_ctrl with GATE_CLKS=100, TIMEOUT_CLKS=1000
module tb_freq_meas_ctrl;
  localparam int CNT_W = 32;
  localparam int TMO   = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sig_in = 1'b0;

  freq_meas_ctrl_if #(.CNT_W(CNT_W)) bus ();

  freq_meas_ctrl #(
    .GATE_CLKS   (100),
    .TIMEOUT_CLKS(TMO),
    .CNT_W       (CNT_W)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .sig_in(sig_in),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc_cnt = 0;

  // 0: low, 1: high, 2: periodic with gen_per/gen_hi
  int gen_mode = 0;
  int gen_per  = 10;
  int gen_hi   = 3;
  int gen_ph   = 0;

  always @(posedge clk) begin
    cyc_cnt = cyc_cnt + 1;
    #2;
    case (gen_mode)
      0: sig_in = 1'b0;
      1: sig_in = 1'b1;
      default: begin
        sig_in = (gen_ph < gen_hi);
        gen_ph = (gen_ph + 1 >= gen_per) ? 0 : gen_ph + 1;
      end
    endcase
  end

  typedef struct {
    int          mode;
    int          per;
    int          hi;
    int          budget;
    logic [31:0] e_sig;
    logic [31:0] e_ref;
    logic [31:0] e_high;
    logic        e_tmo;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_done(input int budget, output bit got, output int stamp);
    got   = 1'b0;
    stamp = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        got   = 1'b1;
        stamp = cyc_cnt;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic set_periodic(input int per, input int hi);
    @(negedge clk);
    gen_per  = per;
    gen_hi   = hi;
    gen_ph   = 0;
    gen_mode = 2;
  endtask

  task automatic chk_results(input string nm, input logic [31:0] s, input logic [31:0] r,
                             input logic [31:0] h, input logic t);
    chk({nm, ".sig_cnt"},  bus.sig_cnt,  s);
    chk({nm, ".ref_cnt"},  bus.ref_cnt,  r);
    chk({nm, ".high_cnt"}, bus.high_cnt, h);
    chk({nm, ".timeout"},  32'(bus.timeout), 32'(t));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".busy"},     32'(bus.busy), 0);
    chk({nm, ".done"},     32'(bus.done), 0);
    chk({nm, ".valid"},    32'(bus.result_valid), 0);
    chk_results(nm, 0, 0, 0, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  initial begin
    bit    got;
    int    stamp, stamp0, extra;
    string nm;

    vecs[0] = '{mode: 2, per: 10, hi: 3, budget: 400,     e_sig: 10, e_ref: 100, e_high: 30, e_tmo: 1'b0};
    vecs[1] = '{mode: 2, per: 7,  hi: 2, budget: 400,     e_sig: 15, e_ref: 105, e_high: 30, e_tmo: 1'b0};
    vecs[2] = '{mode: 0, per: 1,  hi: 0, budget: TMO + 4, e_sig: 0,  e_ref: 0,   e_high: 0,  e_tmo: 1'b1};
    vecs[3] = '{mode: 2, per: 13, hi: 6, budget: 400,     e_sig: 8,  e_ref: 104, e_high: 48, e_tmo: 1'b0};
    vecs[4] = '{mode: 3, per: 1,  hi: 0, budget: TMO + 40, e_sig: 0, e_ref: 0,   e_high: 0,  e_tmo: 1'b1};
    vecs[5] = '{mode: 2, per: 3,  hi: 1, budget: 400,     e_sig: 34, e_ref: 102, e_high: 34, e_tmo: 1'b0};

    bus.start  = 1'b0;
    bus.cont   = 1'b0;
    bus.rd_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      nm = $sformatf("v%0d", i);
      if (vecs[i].mode == 2) set_periodic(vecs[i].per, vecs[i].hi);
      else begin
        @(negedge clk);
        gen_mode = 0;
      end
      repeat (4) @(negedge clk);
      pulse_start();
      if (vecs[i].mode == 3) begin
        repeat (5) @(negedge clk);
        gen_mode = 1;
      end
      wait_done(vecs[i].budget, got, stamp);
      chk({nm, ".done_seen"}, 32'(got), 1);
      chk_results(nm, vecs[i].e_sig, vecs[i].e_ref, vecs[i].e_high, vecs[i].e_tmo);
      chk({nm, ".valid"}, 32'(bus.result_valid), 1);
      chk({nm, ".busy"},  32'(bus.busy), 0);
      extra = 0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (bus.done) extra++;
      end
      chk({nm, ".extra_done"}, extra, 0);
      chk({nm, ".held_sig"}, bus.sig_cnt, vecs[i].e_sig);
      bus.rd_ack = 1'b1;
      @(negedge clk);
      bus.rd_ack = 1'b0;
      chk({nm, ".valid_after_ack"}, 32'(bus.result_valid), 0);
      gen_mode = 0;
    end

    // Continuous mode: fixed 110-cycle cadence, ack handling, then drop cont.
    set_periodic(10, 3);
    repeat (3) @(negedge clk);
    bus.cont = 1'b1;
    pulse_start();
    wait_done(400, got, stamp0);
    chk("cont.done1", 32'(got), 1);
    chk_results("cont.r1", 10, 100, 30, 1'b0);
    chk("cont.busy1", 32'(bus.busy), 1);
    repeat (20) @(negedge clk);
    bus.rd_ack = 1'b1;
    @(negedge clk);
    bus.rd_ack = 1'b0;
    chk("cont.ack_clears", 32'(bus.result_valid), 0);
    wait_done(200, got, stamp);
    chk("cont.done2", 32'(got), 1);
    chk("cont.interval", stamp - stamp0, 110);
    bus.rd_ack = 1'b1;
    @(negedge clk);
    bus.rd_ack = 1'b0;
    chk("cont.ack_with_done", 32'(bus.result_valid), 1);
    chk_results("cont.r2", 10, 100, 30, 1'b0);
    repeat (30) @(negedge clk);
    bus.cont = 1'b0;
    wait_done(200, got, stamp);
    chk("cont.done3", 32'(got), 1);
    chk_results("cont.r3", 10, 100, 30, 1'b0);
    chk("cont.busy_after_drop", 32'(bus.busy), 0);
    extra = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    chk("cont.no_more_done", extra, 0);

    // Second start while busy is ignored.
    pulse_start();
    repeat (40) @(negedge clk);
    chk("busy.mid", 32'(bus.busy), 1);
    pulse_start();
    extra = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    chk("busy.one_done", extra, 1);
    chk("busy.idle_after", 32'(bus.busy), 0);
    chk_results("busy.r", 10, 100, 30, 1'b0);

    // Asynchronous reset in the middle of the gate window.
    pulse_start();
    repeat (50) @(negedge clk);
    chk("rst.busy_before", 32'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("rst.async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.idle", 32'(bus.busy), 0);
    pulse_start();
    wait_done(400, got, stamp);
    chk("rst.done", 32'(got), 1);
    chk_results("rst.r", 10, 100, 30, 1'b0);
    chk("rst.valid", 32'(bus.result_valid), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/freq_meas_ctrl.md
Name: freq_meas_ctrl

Overview:
- Sequencer for the input-frequency / duty measurement path (equal-precision, reciprocal counting).
- Synchronises the external signal and arms on a rising edge.
- Runs a reference-clock gate window, then closes it on the next signal rising edge.
- Latches signal-period count, reference count and high-time count into held result registers for the SPI readback logic.

Parameters:
- GATE_CLKS, 48000000, minimum gate length in CLK cycles.
- TIMEOUT_CLKS, 96000000, max CLK cycles without a signal rising edge before the measurement aborts.
- CNT_W, 32, width of all counters and result registers.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset, asynchronous and active-low.
- sig_in  in  1  measured signal, asynchronous to CLK.
- start  in  1  request one measurement; sampled in IDLE only.
- cont  in  1  1 = re-arm automatically after each result.
- rd_ack  in  1  reader consumed results; clears result_valid.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when results update.
- result_valid  out  1  results unread.
- timeout  out  1  last result aborted by timeout.
- sig_cnt  out  CNT_W  signal rising edges in window.
- ref_cnt  out  CNT_W  CLK cycles in window.
- high_cnt  out  CNT_W  CLK cycles with synchronised signal high in window.

Behaviour:
- Reset: all outputs 0, state IDLE, synchroniser flops 0, all accumulators 0.
- Reset mid-measurement discards all work.
- Synchroniser: s1<=sig_in, s2<=s1, s3<=s2.
- level = s2; rise = s2 & ~s3.
- FSM states IDLE, ARM, GATE, CLOSE.
  - IDLE: start=1 -> ARM next cycle; tmo_cnt<=0.
  - ARM: on rise: ref_acc, sig_acc, high_acc, gate_cnt, tmo_cnt <= 0; -> GATE. This opening edge is not counted.
  - GATE and CLOSE, every cycle: ref_acc+=1; high_acc+=1 if level; sig_acc+=1 if rise.
  - Accumulators saturate at 2^CNT_W-1; no wrap.
  - GATE: gate_cnt+=1 each cycle. The cycle where gate_cnt == GATE_CLKS-1 is gate expiry:
    - rise in that same cycle -> that edge closes the window (results load, exit);
    - otherwise -> CLOSE.
  - CLOSE: first rise closes the window.
- Window close (same cycle as the closing rise):
  - sig_cnt, ref_cnt, high_cnt <= accumulator values including this cycle's increment.
  - timeout<=0, done<=1, result_valid<=1.
  - Next state ARM if cont=1, else IDLE.
  - All these registered outputs are visible the following cycle.
- Timeout:
  - tmo_cnt counts cycles in ARM, GATE and CLOSE; cleared on every rise.
  - tmo_cnt == TIMEOUT_CLKS-1 -> results <= 0, timeout<=1, done<=1, result_valid<=1.
  - Next state follows the same cont rule.
- Results and timeout hold until the next done; done is 1 only for one cycle.
- result_valid cleared by rd_ack. If rd_ack and done occur in the same cycle, done wins (valid stays 1).
- start while busy is ignored.
- cont dropped mid-measurement: the current measurement completes, then IDLE.
- cont=1 in IDLE without start does nothing.
- Invariant for a periodic signal of period P, high H, N periods: sig_cnt=N, ref_cnt=N*P, high_cnt=N*H.

Test Plan (GATE_CLKS=100, TIMEOUT_CLKS=1000, CNT_W=32):
- Period 10, high 3, start pulse -> one done pulse; sig_cnt=10, ref_cnt=100, high_cnt=30, timeout=0, result_valid=1, busy=0 afterwards. Gate expiry coincides with a rise, so this also covers the simultaneous case.
- Period 7, high 2 -> gate expires mid-period, window closes at next edge; sig_cnt=15, ref_cnt=105, high_cnt=30.
- sig_in held 0, start -> done within TIMEOUT_CLKS+4 cycles; timeout=1, all counts 0. Repeat with sig_in stuck 1 after the opening edge -> timeout=1.
- cont=1, period 10 -> done pulses every ~110 cycles with identical results. rd_ack between pulses clears result_valid. rd_ack coincident with done leaves result_valid=1.
- Second start while busy -> ignored, exactly one done. Drop cont mid-window -> current result delivered, then busy=0.
- RST_N pulsed low mid-GATE -> all outputs 0 immediately (async), state IDLE. A new start after release gives correct results (10/100/30).
